// File: rtl/div.sv
// ---------------------------------------------------------------------------
// div -- iterative 32-bit radix-2 restoring divider for DIV/DIVU in EX.
//
// Produces {remainder, quotient} after 32 shift/subtract steps. While an
// operation is outstanding, stallreq_o asks the pipeline controller to
// freeze PC/IF/ID/EX until ready_o is seen.
//
// Configuration macro: DIV_SIGNED_EN
//   defined   : signed_div_i selects signed division (magnitude conversion
//               on entry, sign fix-up on exit).
//   undefined : every operation is unsigned; signed_div_i is ignored and the
//               negation logic is not built. Latency is identical.
//
// Ports:
//   clk          in   pipeline clock, rising edge
//   rst          in   asynchronous, active-high reset
//   signed_div_i in   1 = DIV, 0 = DIVU (sampled at start only)
//   opdata1_i    in   [31:0] dividend (sampled at start only)
//   opdata2_i    in   [31:0] divisor  (sampled at start only)
//   start_i      in   division request, held until ready_o is seen
//   annul_i      in   abort current operation (flush / exception)
//   result_o     out  [63:0] {remainder, quotient}; zero unless ready_o
//   ready_o      out  result valid
//   stallreq_o   out  start_i & ~ready_o & ~annul_i (combinational)
// ---------------------------------------------------------------------------
module div (
    input  logic        clk,
    input  logic        rst,
    input  logic        signed_div_i,
    input  logic [31:0] opdata1_i,
    input  logic [31:0] opdata2_i,
    input  logic        start_i,
    input  logic        annul_i,
    output logic [63:0] result_o,
    output logic        ready_o,
    output logic        stallreq_o
);

    typedef enum logic [1:0] {
        S_FREE   = 2'd0,
        S_BYZERO = 2'd1,
        S_ON     = 2'd2,
        S_END    = 2'd3
    } state_e;

    localparam logic [5:0] LAST_STEP = 6'd32;

    state_e      state_q, state_d;
    logic [5:0]  cnt_q, cnt_d;
    // {partial remainder[64:32], dividend/quotient[31:0]}
    logic [64:0] dd_q, dd_d;
    logic [31:0] dvsr_q, dvsr_d;
    logic [63:0] result_q, result_d;
    logic        ready_q, ready_d;

    // Operand magnitudes and sign flags seen at start.
    logic [31:0] a_mag, b_mag;
    logic [31:0] quo_fix, rem_fix;

`ifdef DIV_SIGNED_EN
    logic        neg_quo_q, neg_quo_d;
    logic        neg_rem_q, neg_rem_d;
    logic        a_neg, b_neg;

    assign a_neg   = signed_div_i & opdata1_i[31];
    assign b_neg   = signed_div_i & opdata2_i[31];
    // Full 32-bit magnitudes: |-2^31| = 32'h8000_0000 needs no special case.
    assign a_mag   = a_neg ? (~opdata1_i + 32'd1) : opdata1_i;
    assign b_mag   = b_neg ? (~opdata2_i + 32'd1) : opdata2_i;
    // Quotient negative when signs differ; remainder follows the dividend.
    assign quo_fix = neg_quo_q ? (~dd_q[31:0] + 32'd1)  : dd_q[31:0];
    assign rem_fix = neg_rem_q ? (~dd_q[63:32] + 32'd1) : dd_q[63:32];
`else
    logic        signed_div_unused;

    assign signed_div_unused = signed_div_i;
    assign a_mag   = opdata1_i;
    assign b_mag   = opdata2_i;
    assign quo_fix = dd_q[31:0];
    assign rem_fix = dd_q[63:32];
`endif

    // -----------------------------------------------------------------------
    // One restoring step. The upper field shifted left by one is 34 bits
    // wide so the borrow of the trial subtract is a clean sign bit even when
    // the previous remainder had its MSB set.
    // -----------------------------------------------------------------------
    logic [33:0] rem_sh;
    logic [33:0] diff;
    logic        diff_ok;
    logic [64:0] step_dd;

    assign rem_sh  = dd_q[64:31];
    assign diff    = rem_sh - {2'b00, dvsr_q};
    assign diff_ok = ~diff[33];
    assign step_dd = {(diff_ok ? diff[32:0] : rem_sh[32:0]), dd_q[30:0], diff_ok};

    // -----------------------------------------------------------------------
    // State / datapath registers
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= S_FREE;
            cnt_q     <= '0;
            dd_q      <= '0;
            dvsr_q    <= '0;
            result_q  <= '0;
            ready_q   <= 1'b0;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            dd_q      <= dd_d;
            dvsr_q    <= dvsr_d;
            result_q  <= result_d;
            ready_q   <= ready_d;
`ifdef DIV_SIGNED_EN
            neg_quo_q <= neg_quo_d;
            neg_rem_q <= neg_rem_d;
`endif
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic. annul_i wins over every other transition once an
    // operation has been accepted.
    // -----------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_FREE: begin
                if (start_i && !annul_i) begin
                    state_d = (opdata2_i == 32'd0) ? S_BYZERO : S_ON;
                end
            end
            S_BYZERO: begin
                state_d = annul_i ? S_FREE : S_END;
            end
            S_ON: begin
                if (annul_i) begin
                    state_d = S_FREE;
                end else if (cnt_q == LAST_STEP) begin
                    state_d = S_END;
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    state_d = S_FREE;
                end
            end
            default: state_d = S_FREE;
        endcase
    end

    // -----------------------------------------------------------------------
    // Datapath / output next values
    // -----------------------------------------------------------------------
    always_comb begin
        cnt_d     = cnt_q;
        dd_d      = dd_q;
        dvsr_d    = dvsr_q;
        result_d  = result_q;
        ready_d   = ready_q;
`ifdef DIV_SIGNED_EN
        neg_quo_d = neg_quo_q;
        neg_rem_d = neg_rem_q;
`endif
        unique case (state_q)
            S_FREE: begin
                result_d = '0;
                ready_d  = 1'b0;
                if (start_i && !annul_i && (opdata2_i != 32'd0)) begin
                    dd_d      = {33'd0, a_mag};
                    dvsr_d    = b_mag;
                    cnt_d     = '0;
`ifdef DIV_SIGNED_EN
                    neg_quo_d = a_neg ^ b_neg;
                    neg_rem_d = a_neg;
`endif
                end
            end
            S_BYZERO: begin
                // Divide by zero reports an all-zero result.
                result_d = '0;
                ready_d  = !annul_i;
            end
            S_ON: begin
                if (annul_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                    cnt_d    = '0;
                end else if (cnt_q == LAST_STEP) begin
                    result_d = {rem_fix, quo_fix};
                    ready_d  = 1'b1;
                end else begin
                    dd_d  = step_dd;
                    cnt_d = cnt_q + 6'd1;
                end
            end
            S_END: begin
                if (annul_i || !start_i) begin
                    result_d = '0;
                    ready_d  = 1'b0;
                end
            end
            default: begin
                result_d = '0;
                ready_d  = 1'b0;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Outputs
    // -----------------------------------------------------------------------
    assign result_o   = result_q;
    assign ready_o    = ready_q;
    assign stallreq_o = start_i & ~ready_q & ~annul_i;

endmodule

// File: tb/tb_div.sv
module tb_div;

    logic        clk = 1'b0;
    logic        rst;
    logic        signed_div;
    logic [31:0] op1, op2;
    logic        start, annul;
    logic [63:0] result;
    logic        ready, stallreq;

    int          checks = 0;
    int          errors = 0;
    logic [63:0] sb[$];
    logic [63:0] last_exp;

    div dut (
        .clk          (clk),
        .rst          (rst),
        .signed_div_i (signed_div),
        .opdata1_i    (op1),
        .opdata2_i    (op2),
        .start_i      (start),
        .annul_i      (annul),
        .result_o     (result),
        .ready_o      (ready),
        .stallreq_o   (stallreq)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout, expected summary");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    // Drive a request at a negedge; push the expected result if it is meant to complete.
    task automatic issue(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                         input logic [63:0] exp, input bit completes);
        signed_div = sgn;
        op1        = a;
        op2        = b;
        annul      = 1'b0;
        start      = 1'b1;
        if (completes) sb.push_back(exp);
        #1;
        check("stall_at_start", {63'd0, stallreq}, 64'd1);
    endtask

    // Count rising edges until ready_o; scramble operands after E0 to show
    // they are not re-sampled.
    task automatic wait_ready(input string tag, input int exp_lat);
        int          lat = 0;
        bit          stall_ok = 1'b1;
        logic [63:0] exp;
        while (ready !== 1'b1 && lat < 100) begin
            cyc();
            lat++;
            if (lat == 1) begin
                op1        = $urandom;
                op2        = $urandom;
                signed_div = ~signed_div;
            end
            if (ready !== 1'b1 && stallreq !== 1'b1) stall_ok = 1'b0;
        end
        exp      = (sb.size() > 0) ? sb.pop_front() : 64'hx;
        last_exp = exp;
        check({tag, "_latency"}, 64'(lat), 64'(exp_lat));
        check({tag, "_stall_held"}, {63'd0, stall_ok}, 64'd1);
        check({tag, "_ready"}, {63'd0, ready}, 64'd1);
        check({tag, "_stall_off"}, {63'd0, stallreq}, 64'd0);
        check({tag, "_result"}, result, exp);
    endtask

    // Optionally hold start_i in END, then drop it and expect FREE next edge.
    task automatic release_start(input string tag, input int hold);
        for (int i = 0; i < hold; i++) begin
            cyc();
            check({tag, "_hold_ready"}, {63'd0, ready}, 64'd1);
            check({tag, "_hold_result"}, result, last_exp);
        end
        start = 1'b0;
        cyc();
        check({tag, "_free_ready"}, {63'd0, ready}, 64'd0);
        check({tag, "_free_result"}, result, 64'd0);
    endtask

    initial begin
        bit rose;
        logic [63:0] e_neg7_2, e_min_m1, e_100_m7;
`ifdef DIV_SIGNED_EN
        e_neg7_2 = 64'hFFFFFFFF_FFFFFFFD;
        e_min_m1 = 64'h00000000_80000000;
        e_100_m7 = 64'h00000002_FFFFFFF2;
`else
        e_neg7_2 = 64'h00000001_7FFFFFFC;
        e_min_m1 = 64'h80000000_00000000;
        e_100_m7 = 64'h00000064_00000000;
`endif
        rst = 1'b1; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
        @(negedge clk);
        check("reset_ready", {63'd0, ready}, 64'd0);
        check("reset_result", result, 64'd0);
        check("reset_stall", {63'd0, stallreq}, 64'd0);
        rst = 1'b0;
        cyc();

        // Unsigned 100 / 7, holding start for two extra cycles in END.
        issue(1'b0, 32'd100, 32'd7, 64'h00000002_0000000E, 1'b1);
        wait_ready("u100_7", 34);
        release_start("u100_7", 2);

        issue(1'b1, 32'hFFFFFFF9, 32'd2, e_neg7_2, 1'b1);
        wait_ready("s_m7_2", 34);
        release_start("s_m7_2", 0);

        issue(1'b1, 32'd100, 32'hFFFFFFF9, e_100_m7, 1'b1);
        wait_ready("s_100_m7", 34);
        release_start("s_100_m7", 0);

        // Divide by zero: ready after E1, zero result.
        issue(1'b0, 32'd5, 32'd0, 64'd0, 1'b1);
        wait_ready("div0", 2);
        release_start("div0", 0);

        issue(1'b1, 32'h80000000, 32'hFFFFFFFF, e_min_m1, 1'b1);
        wait_ready("s_min_m1", 34);
        release_start("s_min_m1", 1);

        // Annul mid-operation.
        issue(1'b0, 32'd100, 32'd7, 64'd0, 1'b0);
        repeat (11) cyc();
        annul = 1'b1;
        #1;
        check("annul_stall", {63'd0, stallreq}, 64'd0);
        cyc();
        check("annul_ready", {63'd0, ready}, 64'd0);
        check("annul_result", result, 64'd0);
        start = 1'b0;
        annul = 1'b0;
        rose  = 1'b0;
        repeat (40) begin
            cyc();
            if (ready !== 1'b0) rose = 1'b1;
        end
        check("annul_no_ready", {63'd0, rose}, 64'd0);
        issue(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b1);
        wait_ready("after_annul", 34);
        release_start("after_annul", 0);

        // Asynchronous reset mid-operation.
        issue(1'b0, 32'd100, 32'd7, 64'd0, 1'b0);
        repeat (21) cyc();
        #2 rst = 1'b1;
        start = 1'b0;
        #1;
        check("rst_mid_ready", {63'd0, ready}, 64'd0);
        check("rst_mid_result", result, 64'd0);
        check("rst_mid_stall", {63'd0, stallreq}, 64'd0);
        @(negedge clk);
        rst = 1'b0;
        cyc();
        issue(1'b0, 32'hFFFFFFFF, 32'd1, 64'h00000000_FFFFFFFF, 1'b1);
        wait_ready("after_rst", 34);
        release_start("after_rst", 0);

        // Asynchronous reset while a result is being held.
        issue(1'b0, 32'd9, 32'd3, 64'h00000000_00000003, 1'b1);
        wait_ready("pre_rst_end", 34);
        #2 rst = 1'b1;
        #1;
        check("rst_end_ready", {63'd0, ready}, 64'd0);
        check("rst_end_result", result, 64'd0);
        start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        cyc();

        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
